// File: rtl/clock_set_ctrl_if.sv
// Front-panel / counter bundle for the time-set controller.
// slave = controller view, master = panel+counter view.
interface clock_set_ctrl_if;
  logic       mode_btn;
  logic       inc_btn;
  logic       cancel_btn;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic       tick;
  logic       load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [1:0] mode;
  logic [4:0] disp_hr;
  logic [5:0] disp_min;

  modport slave (
    input  mode_btn,
    input  inc_btn,
    input  cancel_btn,
    input  cur_hr,
    input  cur_min,
    output tick,
    output load,
    output load_hr,
    output load_min,
    output load_sec,
    output mode,
    output disp_hr,
    output disp_min
  );

  modport master (
    output mode_btn,
    output inc_btn,
    output cancel_btn,
    output cur_hr,
    output cur_min,
    input  tick,
    input  load,
    input  load_hr,
    input  load_min,
    input  load_sec,
    input  mode,
    input  disp_hr,
    input  disp_min
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// 1 Hz tick prescaler and hr/min time-set FSM.
// Commit issues a one-cycle parallel load to the counter.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DIV_W    = 26
) (
  input logic              clk,
  input logic              rst,
  clock_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] TOP =
    DIV_W'(TICK_DIV - 1);

  state_t           state;
  state_t           state_d;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_d;
  logic             tick_q;
  logic             tick_d;
  logic [4:0]       shr;
  logic [4:0]       shr_d;
  logic [5:0]       smin;
  logic [5:0]       smin_d;
  logic             prev_m;
  logic             prev_i;
  logic             prev_c;

  logic             m_raw;
  logic             i_raw;
  logic             c_ev;
  logic             m_ev;
  logic             i_ev;
  logic             setting;

  assign m_raw = bus.mode_btn & ~prev_m;
  assign i_raw = bus.inc_btn & ~prev_i;

  // losing edges are dropped, not queued
  assign c_ev = bus.cancel_btn & ~prev_c;
  assign m_ev = m_raw & ~c_ev;
  assign i_ev = i_raw & ~m_raw & ~c_ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      presc  <= '0;
      tick_q <= 1'b0;
      shr    <= '0;
      smin   <= '0;
      prev_m <= 1'b0;
      prev_i <= 1'b0;
      prev_c <= 1'b0;
    end else begin
      state  <= state_d;
      presc  <= presc_d;
      tick_q <= tick_d;
      shr    <= shr_d;
      smin   <= smin_d;
      prev_m <= bus.mode_btn;
      prev_i <= bus.inc_btn;
      prev_c <= bus.cancel_btn;
    end
  end

  always_comb begin
    state_d = state;
    presc_d = presc;
    tick_d  = 1'b0;
    shr_d   = shr;
    smin_d  = smin;
    unique case (state)
      RUN: begin
        if (presc == TOP) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc + DIV_W'(1);
        end
        if (m_ev) begin
          state_d = SET_HR;
          shr_d   = bus.cur_hr;
          smin_d  = bus.cur_min;
        end
      end
      SET_HR: begin
        unique case (1'b1)
          c_ev: state_d = RUN;
          m_ev: state_d = SET_MIN;
          i_ev: shr_d = (shr >= 5'd23) ?
                  5'd0 : shr + 5'd1;
          default: ;
        endcase
      end
      SET_MIN: begin
        unique case (1'b1)
          c_ev: state_d = RUN;
          m_ev: state_d = COMMIT;
          i_ev: smin_d = (smin >= 6'd59) ?
                  6'd0 : smin + 6'd1;
          default: ;
        endcase
      end
      COMMIT: begin
        // next second after a load is a full period
        presc_d = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign setting = (state != RUN);

  assign bus.tick     = tick_q;
  assign bus.load     = (state == COMMIT);
  assign bus.load_hr  = bus.load ? shr : 5'd0;
  assign bus.load_min = bus.load ? smin : 6'd0;
  assign bus.load_sec = 6'd0;
  assign bus.mode     = state;
  assign bus.disp_hr  = setting ? shr : bus.cur_hr;
  assign bus.disp_min = setting ? smin : bus.cur_min;

endmodule
